traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/tick_gen.sv | 32 +++
 rtl/traffic_phase_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, per-phase sequence states and time-table selectors.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package traffic_pkg;

    // One-hot lamp codes for a single approach
    localparam logic [3:0] LAMP_RED    = 4'b0001;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_GREEN  = 4'b0100;
    localparam logic [3:0] LAMP_LEFT   = 4'b1000;

    // Sequence of intervals an active phase walks through
    typedef enum logic [2:0] {
        ST_GREEN   = 3'd0,
        ST_YELLOW1 = 3'd1,
        ST_LEFT    = 3'd2,
        ST_YELLOW2 = 3'd3,
        ST_CLEAR   = 3'd4
    } phase_state_e;

    // Time-table entry selectors
    localparam logic [1:0] SEL_GREEN  = 2'd0;
    localparam logic [1:0] SEL_YELLOW = 2'd1;
    localparam logic [1:0] SEL_LEFT   = 2'd2;
    localparam logic [1:0] SEL_CLEAR  = 2'd3;

    // Power-on time table, in seconds
    localparam int DEF_GREEN  = 30;
    localparam int DEF_YELLOW = 3;
    localparam int DEF_LEFT   = 10;
    localparam int DEF_CLEAR  = 2;

    // Lamp shown by the active approach in a given interval
    function automatic logic [3:0] state_lamp(input phase_state_e st);
        logic [3:0] l;
        case (st)
            ST_GREEN:   l = LAMP_GREEN;
            ST_YELLOW1: l = LAMP_YELLOW;
            ST_LEFT:    l = LAMP_LEFT;
            ST_YELLOW2: l = LAMP_YELLOW;
            default:    l = LAMP_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: pulses tick for one cycle every TICK_DIV clk cycles.
// Latency: first tick TICK_DIV-1 cycles after the last clr.
// Backpressure: none; clr restarts the count from zero.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNTW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(TICK_DIV - 1);

    logic [CNTW-1:0] cnt;

    // Tick is decoded from the counter, so clr on the same edge cannot loop back into it
    assign tick = (cnt == LAST);

    // Free-running modulo-TICK_DIV counter, restarted by clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase sequencer with per-phase programmable interval times.
// Latency: lamp/count/phase change on the edge after the causing input or tick.
// Backpressure: none; hold freezes sequencing and shows all-red, en low forces idle.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NPHASE   = 4,
    parameter int CW       = 8,
    parameter int TICK_DIV = 50_000_000,
    localparam int PW      = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                hold,
    input  logic                cfg_we,
    input  logic [PW-1:0]       cfg_phase,
    input  logic [1:0]          cfg_sel,
    input  logic [CW-1:0]       cfg_data,
    output logic [4*NPHASE-1:0] lamp,
    output logic [CW-1:0]       count,
    output logic [PW-1:0]       phase
);

    localparam logic [PW-1:0] LAST_PH = PW'(NPHASE - 1);
    localparam logic [PW:0]   NPH_EXT = (PW + 1)'(NPHASE);

    // A zero green time would stall the sequence, so it runs as one second
    function automatic logic [CW-1:0] green_time(input logic [CW-1:0] g);
        return (g == '0) ? CW'(1) : g;
    endfunction

    logic [CW-1:0] tbl [NPHASE][4];

    phase_state_e  state, nxt_state, adv_state;
    logic [PW-1:0] phase_q, nxt_phase, adv_phase, next_ph;
    logic [CW-1:0] count_q, nxt_count, adv_count;
    logic          idle, nxt_idle;
    logic          frozen, nxt_frozen;
    logic          load;
    logic          tick;
    logic          clr;
    logic          cfg_ok;
    logic [CW-1:0] t_yel, t_left, t_clr;

    assign cfg_ok = ({1'b0, cfg_phase} < NPH_EXT);

    // Prescaler restarts on every interval load and whenever sequencing is not running
    assign clr = !en || hold || idle || load;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // Time table: defaults on reset, single-entry writes otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPHASE; p++) begin
                tbl[p][SEL_GREEN]  <= CW'(DEF_GREEN);
                tbl[p][SEL_YELLOW] <= CW'(DEF_YELLOW);
                tbl[p][SEL_LEFT]   <= CW'(DEF_LEFT);
                tbl[p][SEL_CLEAR]  <= CW'(DEF_CLEAR);
            end
        end else if (cfg_we && cfg_ok) begin
            tbl[cfg_phase][cfg_sel] <= cfg_data;
        end
    end

    // Successor interval after the current one expires, skipping zero-time intervals.
    // Reads the table before any same-edge write, so a colliding write applies next load.
    always_comb begin
        t_yel     = tbl[phase_q][SEL_YELLOW];
        t_left    = tbl[phase_q][SEL_LEFT];
        t_clr     = tbl[phase_q][SEL_CLEAR];
        next_ph   = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
        adv_state = ST_GREEN;
        adv_phase = next_ph;
        adv_count = green_time(tbl[next_ph][SEL_GREEN]);
        case (state)
            ST_GREEN: begin
                if (t_yel != '0)       adv_state = ST_YELLOW1;
                else if (t_left != '0) adv_state = ST_LEFT;
                else if (t_clr != '0)  adv_state = ST_CLEAR;
            end
            ST_YELLOW1: begin
                if (t_left != '0)      adv_state = ST_LEFT;
                else if (t_clr != '0)  adv_state = ST_CLEAR;
            end
            ST_LEFT: begin
                if (t_yel != '0)       adv_state = ST_YELLOW2;
                else if (t_clr != '0)  adv_state = ST_CLEAR;
            end
            ST_YELLOW2: begin
                if (t_clr != '0)       adv_state = ST_CLEAR;
            end
            default: adv_state = ST_GREEN;
        endcase
        if (adv_state != ST_GREEN) begin
            adv_phase = phase_q;
            case (adv_state)
                ST_YELLOW1, ST_YELLOW2: adv_count = t_yel;
                ST_LEFT:                adv_count = t_left;
                default:                adv_count = t_clr;
            endcase
        end
    end

    // Next-state: en low beats hold, hold beats tick; count==1 on a tick loads the next interval
    always_comb begin
        nxt_idle   = idle;
        nxt_frozen = frozen;
        nxt_state  = state;
        nxt_phase  = phase_q;
        nxt_count  = count_q;
        load       = 1'b0;
        if (!en) begin
            nxt_idle   = 1'b1;
            nxt_frozen = 1'b0;
            nxt_state  = ST_GREEN;
            nxt_phase  = '0;
            nxt_count  = '0;
        end else if (hold) begin
            nxt_frozen = !idle;
        end else if (idle) begin
            nxt_idle   = 1'b0;
            nxt_frozen = 1'b0;
            nxt_state  = ST_GREEN;
            nxt_phase  = '0;
            nxt_count  = green_time(tbl[0][SEL_GREEN]);
            load       = 1'b1;
        end else begin
            nxt_frozen = 1'b0;
            if (tick) begin
                if (count_q > CW'(1)) begin
                    nxt_count = count_q - 1'b1;
                end else begin
                    nxt_state = adv_state;
                    nxt_phase = adv_phase;
                    nxt_count = adv_count;
                    load      = 1'b1;
                end
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle    <= 1'b1;
            frozen  <= 1'b0;
            state   <= ST_GREEN;
            phase_q <= '0;
            count_q <= '0;
        end else begin
            idle    <= nxt_idle;
            frozen  <= nxt_frozen;
            state   <= nxt_state;
            phase_q <= nxt_phase;
            count_q <= nxt_count;
        end
    end

    // Lamp decode: only the active approach shows its interval colour, and only while running
    always_comb begin
        lamp = '0;
        for (int p = 0; p < NPHASE; p++) begin
            if (!idle && !frozen && (phase_q == PW'(p))) begin
                lamp[4*p +: 4] = state_lamp(state);
            end else begin
                lamp[4*p +: 4] = LAMP_RED;
            end
        end
    end

    assign count = count_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl with NPHASE=2, CW=8, TICK_DIV=2.
// Latency: expectations are queued at drive time and compared one edge later.
// Backpressure: n/a.
module tb_traffic_phase_ctrl;

    localparam int NPHASE   = 2;
    localparam int CW       = 8;
    localparam int TICK_DIV = 2;
    localparam int PW       = 1;

    localparam logic [3:0] L_RED = 4'b0001;
    localparam logic [3:0] L_YEL = 4'b0010;
    localparam logic [3:0] L_GRN = 4'b0100;
    localparam logic [3:0] L_LFT = 4'b1000;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                hold;
    logic                cfg_we;
    logic [PW-1:0]       cfg_phase;
    logic [1:0]          cfg_sel;
    logic [CW-1:0]       cfg_data;
    logic [4*NPHASE-1:0] lamp;
    logic [CW-1:0]       count;
    logic [PW-1:0]       phase;

    traffic_phase_ctrl #(
        .NPHASE   (NPHASE),
        .CW       (CW),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .hold      (hold),
        .cfg_we    (cfg_we),
        .cfg_phase (cfg_phase),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .lamp      (lamp),
        .count     (count),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model (states: 0 green, 1 yellow1, 2 left, 3 yellow2, 4 clear)
    int m_idle, m_frozen, m_st, m_ph, m_cnt, m_pre;
    int m_tbl [NPHASE][4];

    typedef struct {
        logic [4*NPHASE-1:0] lamp;
        int                  cnt;
        int                  ph;
    } exp_t;

    exp_t sb[$];

    function automatic int tsel(input int st);
        case (st)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int present(input int ph, input int st);
        case (st)
            0: return 1;
            1: return (m_tbl[ph][1] != 0) ? 1 : 0;
            2: return (m_tbl[ph][2] != 0) ? 1 : 0;
            3: return (m_tbl[ph][1] != 0 && m_tbl[ph][2] != 0) ? 1 : 0;
            default: return (m_tbl[ph][3] != 0) ? 1 : 0;
        endcase
    endfunction

    function automatic int dur(input int ph, input int st);
        int v;
        v = m_tbl[ph][tsel(st)];
        if (st == 0 && v == 0) v = 1;
        return v;
    endfunction

    function automatic logic [4*NPHASE-1:0] exp_lamp();
        logic [4*NPHASE-1:0] l;
        logic [3:0] c;
        case (m_st)
            0: c = L_GRN;
            1: c = L_YEL;
            2: c = L_LFT;
            3: c = L_YEL;
            default: c = L_RED;
        endcase
        for (int p = 0; p < NPHASE; p++) begin
            l[4*p +: 4] = (m_idle == 0 && m_frozen == 0 && m_ph == p) ? c : L_RED;
        end
        return l;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_frozen = 0; m_st = 0; m_ph = 0; m_cnt = 0; m_pre = 0;
        for (int p = 0; p < NPHASE; p++) begin
            m_tbl[p][0] = 30; m_tbl[p][1] = 3; m_tbl[p][2] = 10; m_tbl[p][3] = 2;
        end
    endtask

    task automatic model_edge();
        int tk, clr, s, p;
        tk  = (m_pre == TICK_DIV - 1) ? 1 : 0;
        clr = 0;
        if (!en) begin
            m_idle = 1; m_frozen = 0; m_st = 0; m_ph = 0; m_cnt = 0; clr = 1;
        end else if (hold) begin
            if (m_idle == 0) m_frozen = 1;
            clr = 1;
        end else if (m_idle != 0) begin
            m_idle = 0; m_frozen = 0; m_st = 0; m_ph = 0; m_cnt = dur(0, 0); clr = 1;
        end else begin
            m_frozen = 0;
            if (tk != 0) begin
                if (m_cnt > 1) begin
                    m_cnt--;
                end else begin
                    s = m_st; p = m_ph;
                    do begin
                        s++;
                        if (s == 5) begin s = 0; p = (p + 1) % NPHASE; end
                    end while (present(p, s) == 0);
                    m_st = s; m_ph = p; m_cnt = dur(p, s); clr = 1;
                end
            end
        end
        m_pre = (clr != 0 || tk != 0) ? 0 : m_pre + 1;
        if (cfg_we && cfg_phase < NPHASE) m_tbl[cfg_phase][cfg_sel] = cfg_data;
    endtask

    // One clock: predict, queue, then compare the DUT after the edge
    task automatic cycle();
        exp_t e;
        exp_t g;
        model_edge();
        e.lamp = exp_lamp(); e.cnt = m_cnt; e.ph = m_ph;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("lamp", 32'(lamp), 32'(g.lamp));
        check("count", 32'(count), 32'(g.cnt));
        check("phase", 32'(phase), 32'(g.ph));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cfg_write(input int ph, input int sel, input int val);
        cfg_we = 1'b1; cfg_phase = PW'(ph); cfg_sel = 2'(sel); cfg_data = CW'(val);
        cycle();
        cfg_we = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; hold = 1'b0;
        cfg_we = 1'b0; cfg_phase = '0; cfg_sel = '0; cfg_data = '0;
        model_reset();
        #12;
        check("rst_lamp", 32'(lamp), 32'h11);
        check("rst_count", 32'(count), 0);
        check("rst_phase", 32'(phase), 0);
        rst = 1'b0;
        cycles(2);

        // Default table sequence across both phases
        en = 1'b1;
        cycle();
        check("s1_green_lamp", 32'(lamp), 32'h14);
        check("s1_green_count", 32'(count), 30);
        cycles(60);
        check("s1_yel1", 32'(lamp), 32'h12);
        check("s1_yel1_count", 32'(count), 3);
        cycles(6);
        check("s1_left", 32'(lamp), 32'h18);
        check("s1_left_count", 32'(count), 10);
        cycles(20);
        check("s1_yel2", 32'(lamp), 32'h12);
        cycles(6);
        check("s1_clear", 32'(lamp), 32'h11);
        check("s1_clear_count", 32'(count), 2);
        check("s1_clear_phase", 32'(phase), 0);
        cycles(4);
        check("s1_ph1_lamp", 32'(lamp), 32'h41);
        check("s1_ph1_count", 32'(count), 30);
        check("s1_ph1_phase", 32'(phase), 1);

        // Phase 0 with no left turn: green, one yellow, clearance
        cfg_write(0, 2, 0);
        en = 1'b0; cycle();
        en = 1'b1; cycle();
        cycles(60);
        check("s2_yel", 32'(lamp), 32'h12);
        cycles(6);
        check("s2_clear", 32'(lamp), 32'h11);
        check("s2_clear_count", 32'(count), 2);
        cycles(4);
        check("s2_ph1", 32'(lamp), 32'h41);
        cfg_write(0, 2, 10);

        // Hold at count 17 in green
        en = 1'b0; cycle();
        en = 1'b1; cycle();
        cycles(26);
        check("s3_pre17", 32'(count), 17);
        hold = 1'b1;
        cycles(6);
        check("s3_hold_lamp", 32'(lamp), 32'h11);
        check("s3_hold_count", 32'(count), 17);
        hold = 1'b0;
        cycle();
        check("s3_resume_lamp", 32'(lamp), 32'h14);
        check("s3_resume_count", 32'(count), 17);
        cycle();
        check("s3_dec", 32'(count), 16);

        // en dropped during left turn
        k = 0;
        while (m_st != 2 && k < 200) begin cycle(); k++; end
        check("s4_reach_left", 32'(m_st), 2);
        cycles(3);
        en = 1'b0; cycle();
        check("s4_idle_lamp", 32'(lamp), 32'h11);
        check("s4_idle_count", 32'(count), 0);
        check("s4_idle_phase", 32'(phase), 0);
        en = 1'b1; cycle();
        check("s4_restart", 32'(lamp), 32'h14);
        check("s4_restart_count", 32'(count), 30);

        // Write phase1 green on the very edge it loads
        k = 0;
        while (!(m_ph == 0 && m_st == 4 && m_cnt == 1 && m_pre == TICK_DIV - 1) && k < 300) begin
            cycle(); k++;
        end
        check("s5_reach", 32'(k < 300), 1);
        cfg_write(1, 0, 7);
        check("s5_old_count", 32'(count), 30);
        check("s5_old_phase", 32'(phase), 1);
        k = 0;
        while (m_ph == 1 && k < 300) begin cycle(); k++; end
        while (m_ph != 1 && k < 600) begin cycle(); k++; end
        check("s5_reach2", 32'(k < 600), 1);
        check("s5_new_count", 32'(count), 7);
        check("s5_new_lamp", 32'(lamp), 32'h41);

        // Reset during phase1 yellow
        k = 0;
        while (!(m_ph == 1 && m_st == 1) && k < 100) begin cycle(); k++; end
        check("s6_reach_yel", 32'(lamp), 32'h21);
        cycle();
        rst = 1'b1;
        #1;
        model_reset();
        check("s6_rst_lamp", 32'(lamp), 32'h11);
        check("s6_rst_count", 32'(count), 0);
        check("s6_rst_phase", 32'(phase), 0);
        @(posedge clk);
        #1;
        check("s6_rst_hold", 32'(lamp), 32'h11);
        rst = 1'b0;
        cycle();
        check("s6_green", 32'(count), 30);
        cycles(96);
        check("s6_ph1_default", 32'(count), 30);
        check("s6_ph1_phase", 32'(phase), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
